// File: rtl/bcd2bin_if.sv
// bcd2bin_if: start/ready/done_tick handshake and data bundle for the BCD-to-binary converter
interface bcd2bin_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ready;
    logic                  done_tick;
    logic [BIN_W-1:0]      bin;
    logic                  err;
    modport master (output start, bcd, input ready, done_tick, bin, err);
    modport slave  (input start, bcd, output ready, done_tick, bin, err);
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin: sequential reverse double-dabble BCD-to-binary converter (shift right, subtract-3 per digit >= 8).
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits > 9 via err (bin forced to 0 on error).
module bcd2bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input logic      clk,
    input logic      reset,
    bcd2bin_if.slave io
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
    state_t              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_d, corr;
    logic [BIN_W-1:0]    acc_q, acc_d, bin_q, bin_d;
    logic [CW-1:0]       n_q, n_d;
    logic [BW+BIN_W-1:0] sh;
    assign sh = {bcd_q, acc_q} >> 1;
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign corr[4*d +: 4] = sh[BIN_W+4*d +: 4] >= 4'd8 ? sh[BIN_W+4*d +: 4] - 4'd3 : sh[BIN_W+4*d +: 4];
    end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic              err_q, err_d, flag_q, flag_d, bad_any;
    logic [DIGITS-1:0] bad;
    for (genvar d = 0; d < DIGITS; d++) begin : g_chk
        assign bad[d] = io.bcd[4*d +: 4] > 4'd9;
    end
    assign bad_any = |bad;
    assign io.err  = err_q;
`else
    assign io.err = 1'b0;
`endif
    assign io.ready     = state_q == IDLE;
    assign io.done_tick = state_q == DONE;
    assign io.bin       = bin_q;
    // The result is captured on the final step so it is already valid while done_tick is high.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        n_d     = n_q;
        bin_d   = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d   = err_q;
        flag_d  = flag_q;
`endif
        case (state_q)
            IDLE: if (io.start) begin
                state_d = OP;
                bcd_d   = io.bcd;
                acc_d   = '0;
                n_d     = CW'(BIN_W);
`ifdef BCD2BIN_DIGIT_CHECK_EN
                flag_d  = bad_any;
`endif
            end
            OP: begin
                bcd_d = corr;
                acc_d = sh[BIN_W-1:0];
                n_d   = n_q - CW'(1);
                if (n_q == CW'(1)) begin
                    state_d = DONE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bin_d   = flag_q ? '0 : sh[BIN_W-1:0];
                    err_d   = flag_q;
`else
                    bin_d   = sh[BIN_W-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            bin_q   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            bin_q   <= bin_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q   <= err_d;
            flag_q  <= flag_d;
`endif
        end
    end
endmodule
